vga_sync_gen: RTL and testbench

Generates the 640x480 @ 60 Hz VGA raster timing for the game display from the 50 MHz system clock, using an internal divide-by-2 pixel enable instead of a derived 25 MHz clock. It consumes the pixel rate produced by the divider and emits registered sync, blanking, pixel coordinates and line/frame strobes. The renderer and note-lane logic use these outputs to produce RGB for the current pixel.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/pixel_tick_gen.sv | 16 +
 rtl/vga_sync_gen.sv | 101 ++++++++++
 tb/tb_vga_sync_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz raster constants shared by the sync generator and pixel-rate logic.
// Latency: n/a (constants only).
// Backpressure: n/a (no flow control).
package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  // Vertical timing, in lines
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Width of pixel_x / pixel_y
  localparam int COORD_W = 10;

endpackage

// File: rtl/pixel_tick_gen.sv
// Divide-by-2 pixel enable: pix_tick toggles every clk, giving a 25 MHz-rate enable from 50 MHz.
// Latency: first high on the 1st rising edge after rst_n release.
// Backpressure: none; free-running.
module pixel_tick_gen (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  // Toggle flop; starts low so the first advance happens on the 2nd edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_tick <= 1'b0;
    else        pix_tick <= ~pix_tick;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters with registered sync, blanking and line/frame strobes.
// Latency: sync/video_on change on the same edge as the counters (zero skew).
// Backpressure: none; free-running, advances on every pixel enable.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               pix_tick,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Boundaries pre-sized to the coordinate width so all compares are same-width unsigned
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               hsync_nxt;
  logic               vsync_nxt;
  logic               video_on_nxt;
  logic               line_nxt;
  logic               frame_nxt;

  pixel_tick_gen u_pixel_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  // Next raster position and the decodes of that position, so outputs line up with the counters
  always_comb begin
    x_nxt     = pixel_x;
    y_nxt     = pixel_y;
    line_nxt  = 1'b0;
    frame_nxt = 1'b0;
    if (pix_tick) begin
      if (pixel_x == H_LAST) begin
        x_nxt    = '0;
        line_nxt = 1'b1;
        if (pixel_y == V_LAST) begin
          y_nxt     = '0;
          frame_nxt = 1'b1;
        end else begin
          y_nxt = pixel_y + COORD_W'(1);
        end
      end else begin
        x_nxt = pixel_x + COORD_W'(1);
      end
    end
    hsync_nxt    = ~((x_nxt >= HS_START) && (x_nxt < HS_END));
    vsync_nxt    = ~((y_nxt >= VS_START) && (y_nxt < VS_END));
    video_on_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  // Output registers; reset parks the raster on its last position so outputs stay self-consistent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x    <= H_LAST;
      pixel_y    <= V_LAST;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pixel_x    <= x_nxt;
      pixel_y    <= y_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      video_on   <= video_on_nxt;
      line_tick  <= line_nxt;
      frame_tick <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size raster (reset, first line) and reduced raster (frames, async reset).
// Expected values are hand-computed snapshots/counts queued per cycle and checked by per-instance monitors.
// Cycle k = k-th rising edge after rst_n release; outputs sampled 1 time unit after the falling edge.
module tb_vga_sync_gen;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  logic       hs_a, vs_a, von_a, pt_a, lt_a, ft_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, von_b, pt_b, lt_b, ft_b;
  logic [9:0] x_b, y_b;

  typedef struct {
    int cyc;
    int kind;   // 0: output snapshot, 1: cumulative counts since release
    int x, y, hs, vs, von, pt, lt, ft;
    int c_hs, c_vs, c_von, c_lt, c_ft;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_a = 0;
  int   cyc_b = 0;

  always #10 clk = ~clk;

  vga_sync_gen u_big (
    .clk(clk), .rst_n(rst_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .pixel_x(x_a), .pixel_y(y_a), .pix_tick(pt_a), .line_tick(lt_a), .frame_tick(ft_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clk(clk), .rst_n(rst_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .pixel_x(x_b), .pixel_y(y_b), .pix_tick(pt_b), .line_tick(lt_b), .frame_tick(ft_b)
  );

  always @(posedge clk or negedge rst_a)
    if (!rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void cmp(string tag, exp_t e, exp_t a);
    string p = $sformatf("%s_c%0d", tag, e.cyc);
    if (e.kind == 0) begin
      chk({p, "_pixel_x"},    a.x,   e.x);
      chk({p, "_pixel_y"},    a.y,   e.y);
      chk({p, "_hsync"},      a.hs,  e.hs);
      chk({p, "_vsync"},      a.vs,  e.vs);
      chk({p, "_video_on"},   a.von, e.von);
      chk({p, "_pix_tick"},   a.pt,  e.pt);
      chk({p, "_line_tick"},  a.lt,  e.lt);
      chk({p, "_frame_tick"}, a.ft,  e.ft);
    end else begin
      chk({p, "_hsync_low_clks"},  a.c_hs,  e.c_hs);
      chk({p, "_vsync_low_clks"},  a.c_vs,  e.c_vs);
      chk({p, "_video_on_clks"},   a.c_von, e.c_von);
      chk({p, "_line_ticks"},      a.c_lt,  e.c_lt);
      chk({p, "_frame_ticks"},     a.c_ft,  e.c_ft);
    end
  endfunction

  task automatic push_snap(input int inst, input int cyc, input int x, input int y,
                           input int hs, input int vs, input int von, input int pt,
                           input int lt, input int ft);
    exp_t e;
    e = '{cyc: cyc, kind: 0, x: x, y: y, hs: hs, vs: vs, von: von, pt: pt, lt: lt, ft: ft,
          c_hs: 0, c_vs: 0, c_von: 0, c_lt: 0, c_ft: 0};
    if (inst == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic push_cnt(input int inst, input int cyc, input int c_hs, input int c_vs,
                          input int c_von, input int c_lt, input int c_ft);
    exp_t e;
    e = '{cyc: cyc, kind: 1, x: 0, y: 0, hs: 0, vs: 0, von: 0, pt: 0, lt: 0, ft: 0,
          c_hs: c_hs, c_vs: c_vs, c_von: c_von, c_lt: c_lt, c_ft: c_ft};
    if (inst == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  task automatic wait_cyc(input int inst, input int target);
    int cur;
    cur = (inst == 0) ? cyc_a : cyc_b;
    for (int i = 0; i < target + 100 && cur < target; i++) begin
      @(negedge clk);
      cur = (inst == 0) ? cyc_a : cyc_b;
    end
    if (cur < target) begin
      total++;
      bad++;
      $display("FAIL wait_inst%0d: reached cycle %0d expected %0d", inst, cur, target);
    end
  endtask

  // Monitor for the full-size raster
  initial begin : mon_a
    int   c_hs, c_vs, c_von, c_lt, c_ft;
    exp_t act, e;
    c_hs = 0; c_vs = 0; c_von = 0; c_lt = 0; c_ft = 0;
    forever begin
      @(negedge clk or negedge rst_a);
      #1;
      if (!rst_a) begin
        c_hs = 0; c_vs = 0; c_von = 0; c_lt = 0; c_ft = 0;
      end else if (cyc_a >= 1) begin
        c_hs += int'(!hs_a); c_vs += int'(!vs_a); c_von += int'(von_a);
        c_lt += int'(lt_a);  c_ft += int'(ft_a);
      end
      act = '{cyc: cyc_a, kind: 0, x: int'(x_a), y: int'(y_a), hs: int'(hs_a), vs: int'(vs_a),
              von: int'(von_a), pt: int'(pt_a), lt: int'(lt_a), ft: int'(ft_a),
              c_hs: c_hs, c_vs: c_vs, c_von: c_von, c_lt: c_lt, c_ft: c_ft};
      while (qa.size() > 0 && qa[0].cyc <= cyc_a) begin
        e = qa.pop_front();
        if (e.cyc < cyc_a) chk("big_missed_sample_cycle", cyc_a, e.cyc);
        else               cmp("big", e, act);
      end
    end
  end

  // Monitor for the reduced raster
  initial begin : mon_b
    int   c_hs, c_vs, c_von, c_lt, c_ft;
    exp_t act, e;
    c_hs = 0; c_vs = 0; c_von = 0; c_lt = 0; c_ft = 0;
    forever begin
      @(negedge clk or negedge rst_b);
      #1;
      if (!rst_b) begin
        c_hs = 0; c_vs = 0; c_von = 0; c_lt = 0; c_ft = 0;
      end else if (cyc_b >= 1) begin
        c_hs += int'(!hs_b); c_vs += int'(!vs_b); c_von += int'(von_b);
        c_lt += int'(lt_b);  c_ft += int'(ft_b);
      end
      act = '{cyc: cyc_b, kind: 0, x: int'(x_b), y: int'(y_b), hs: int'(hs_b), vs: int'(vs_b),
              von: int'(von_b), pt: int'(pt_b), lt: int'(lt_b), ft: int'(ft_b),
              c_hs: c_hs, c_vs: c_vs, c_von: c_von, c_lt: c_lt, c_ft: c_ft};
      while (qb.size() > 0 && qb[0].cyc <= cyc_b) begin
        e = qb.pop_front();
        if (e.cyc < cyc_b) chk("small_missed_sample_cycle", cyc_b, e.cyc);
        else               cmp("small", e, act);
      end
    end
  end

  // Full raster: reset state, first advance, one complete line
  task automatic stim_a();
    //            cyc   x    y   hs vs von pt lt ft
    push_snap(0, 0,    799, 524, 1, 1, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    push_snap(0, 1,    799, 524, 1, 1, 0, 1, 0, 0);
    push_snap(0, 2,    0,   0,   1, 1, 1, 0, 1, 1);
    push_snap(0, 3,    0,   0,   1, 1, 1, 1, 0, 0);
    push_snap(0, 4,    1,   0,   1, 1, 1, 0, 0, 0);
    push_snap(0, 1281, 639, 0,   1, 1, 1, 1, 0, 0);
    push_snap(0, 1282, 640, 0,   1, 1, 0, 0, 0, 0);
    push_snap(0, 1313, 655, 0,   1, 1, 0, 1, 0, 0);
    push_snap(0, 1314, 656, 0,   0, 1, 0, 0, 0, 0);
    push_snap(0, 1505, 751, 0,   0, 1, 0, 1, 0, 0);
    push_snap(0, 1506, 752, 0,   1, 1, 0, 0, 0, 0);
    push_snap(0, 1601, 799, 0,   1, 1, 0, 1, 0, 0);
    //          cyc   hs_low vs_low von  lt ft
    push_cnt(0, 1601, 192,   0,     1280, 1, 1);
    push_snap(0, 1602, 0,   1,   1, 1, 1, 0, 1, 0);
    push_snap(0, 1603, 0,   1,   1, 1, 1, 1, 0, 0);
    wait_cyc(0, 1604);
  endtask

  // Reduced raster (14x7): two frames, boundaries, then async reset mid-frame
  task automatic stim_b();
    push_snap(1, 0,   13, 6, 1, 1, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    push_snap(1, 1,   13, 6, 1, 1, 0, 1, 0, 0);
    push_snap(1, 2,   0,  0, 1, 1, 1, 0, 1, 1);
    push_snap(1, 3,   0,  0, 1, 1, 1, 1, 0, 0);
    push_snap(1, 4,   1,  0, 1, 1, 1, 0, 0, 0);
    push_snap(1, 17,  7,  0, 1, 1, 1, 1, 0, 0);
    push_snap(1, 18,  8,  0, 1, 1, 0, 0, 0, 0);
    push_snap(1, 21,  9,  0, 1, 1, 0, 1, 0, 0);
    push_snap(1, 22,  10, 0, 0, 1, 0, 0, 0, 0);
    push_snap(1, 25,  11, 0, 0, 1, 0, 1, 0, 0);
    push_snap(1, 26,  12, 0, 1, 1, 0, 0, 0, 0);
    push_snap(1, 29,  13, 0, 1, 1, 0, 1, 0, 0);
    push_snap(1, 30,  0,  1, 1, 1, 1, 0, 1, 0);
    push_snap(1, 100, 7,  3, 1, 1, 1, 0, 0, 0);
    push_snap(1, 114, 0,  4, 1, 1, 0, 0, 1, 0);
    push_snap(1, 141, 13, 4, 1, 1, 0, 1, 0, 0);
    push_snap(1, 142, 0,  5, 1, 0, 0, 0, 1, 0);
    push_snap(1, 162, 10, 5, 0, 0, 0, 0, 0, 0);
    push_snap(1, 170, 0,  6, 1, 1, 0, 0, 1, 0);
    push_snap(1, 197, 13, 6, 1, 1, 0, 1, 0, 0);
    push_snap(1, 198, 0,  0, 1, 1, 1, 0, 1, 1);
    push_cnt(1, 393, 56, 56, 128, 14, 2);
    push_snap(1, 394, 0,  0, 1, 1, 1, 0, 1, 1);
    push_snap(1, 488, 5,  3, 1, 1, 1, 0, 0, 0);
    wait_cyc(1, 488);
    #3;
    push_snap(1, 0,   13, 6, 1, 1, 0, 0, 0, 0);
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    push_snap(1, 1,   13, 6, 1, 1, 0, 1, 0, 0);
    push_snap(1, 2,   0,  0, 1, 1, 1, 0, 1, 1);
    push_snap(1, 3,   0,  0, 1, 1, 1, 1, 0, 0);
    push_snap(1, 4,   1,  0, 1, 1, 1, 0, 0, 0);
    rst_b = 1'b1;
    wait_cyc(1, 6);
  endtask

  initial begin : main
    fork
      stim_a();
      stim_b();
    join
    repeat (4) @(negedge clk);
    #2;
    chk("big_pending_entries",   qa.size(), 0);
    chk("small_pending_entries", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
